// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared codes for the ALU control / mul-div sequencer: ALU ops, branch and memory size codes,
// M-extension funct3 values, FSM states and the R-type function decode helper.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_fn_e;

  typedef enum logic [1:0] {
    EQC_NONE = 2'b00,
    EQC_NZ   = 2'b10,
    EQC_Z    = 2'b11
  } eqc_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'b000,
    MEM_B    = 3'b001,
    MEM_H    = 3'b010,
    MEM_W    = 3'b011,
    MEM_HU   = 3'b100,
    MEM_BU   = 3'b101
  } mem_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_e;

  function automatic alu_fn_e r_fn(input logic f7b5, input logic [2:0] f3);
    alu_fn_e fn;
    case ({f7b5, f3})
      4'b0000: fn = ALU_ADD;
      4'b1000: fn = ALU_SUB;
      4'b0001: fn = ALU_SLL;
      4'b0010: fn = ALU_SLT;
      4'b0011: fn = ALU_SLTU;
      4'b0100: fn = ALU_XOR;
      4'b0101: fn = ALU_SRL;
      4'b1101: fn = ALU_SRA;
      4'b0110: fn = ALU_OR;
      4'b0111: fn = ALU_AND;
      default: fn = ALU_ADD;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// Decoder-side bundle: instruction fields and operands in, ALU/branch/memory codes and
// mul-div handshake out.
interface alu_ctrl_muldiv_if #(parameter int XLEN = 32);
  logic            ALU_En;
  logic            op_valid;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic [3:0]      out_to_alu;
  logic [1:0]      equal_comp;
  logic [2:0]      mem;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output ALU_En, op_valid, alu_op, funct3, funct7, rs1_val, rs2_val, flush,
    input  out_to_alu, equal_comp, mem, md_busy, md_done, md_result
  );

  modport slave (
    input  ALU_En, op_valid, alu_op, funct3, funct7, rs1_val, rs2_val, flush,
    output out_to_alu, equal_comp, mem, md_busy, md_done, md_result
  );
endinterface

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide on magnitudes,
// MD_UNROLL bits per step, with a down-counting step counter.
module muldiv_iter #(
  parameter int XLEN      = 32,
  parameter int MD_UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_nxt_o,
  output logic              last_o
);

  localparam int N  = XLEN / MD_UNROLL;
  localparam int CW = $clog2(N + 1);

  // acc holds {high product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN:0]     part;

  always_comb begin
    acc_d = acc_q;
    part  = '0;
    for (int i = 0; i < MD_UNROLL; i++) begin
      if (is_div_i) begin
        part = {acc_d[2*XLEN-1:XLEN], acc_d[XLEN-1]};
        if (part >= {1'b0, b_q}) begin
          part  = part - {1'b0, b_q};
          acc_d = {part[XLEN-1:0], acc_d[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {part[XLEN-1:0], acc_d[XLEN-2:0], 1'b0};
        end
      end else begin
        part  = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        acc_d = {part, acc_d[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= {{XLEN{1'b0}}, a_i};
      b_q   <= b_i;
      cnt_q <= CW'(N);
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign acc_nxt_o = acc_d;
  assign last_o    = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus RV32M sequencer that stalls the core while an M op computes.
// state   | meaning
// IDLE    | decode only; accepts an M op (busy this cycle)
// MUL/DIV | iterating, busy
// DONE    | md_done pulse, md_result valid, back to IDLE
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_UNROLL = 1,
  parameter int EN_M      = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_ctrl_muldiv_if.slave  bus
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q;
  logic              md_done_q;
  logic [XLEN-1:0]   md_result_q;
  logic [2:0]        f3_q;
  logic              a_neg_q, b_neg_q;

  logic              m_op, accept, step, iter_last;
  logic [2*XLEN-1:0] acc_nxt;
  logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s, r_s;
  alu_fn_e           alu_fn;
  eqc_e              eqc;
  mem_e              mem_sz;

  assign m_op   = (EN_M != 0) && !bus.ALU_En && bus.op_valid &&
                  (bus.alu_op == 2'b00) && (bus.funct7 == F7_MULDIV);
  assign accept = (state_q == ST_IDLE) && m_op && !bus.flush;
  assign step   = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !bus.flush;

  always_comb begin
    alu_fn = ALU_ADD;
    eqc    = EQC_NONE;
    mem_sz = MEM_NONE;
    if (!bus.ALU_En && !m_op) begin
      case (bus.alu_op)
        2'b00: alu_fn = r_fn(bus.funct7[5], bus.funct3);
        2'b01: alu_fn = r_fn((bus.funct3 == 3'b101) && bus.funct7[5], bus.funct3);
        2'b10: begin
          case (bus.funct3)
            3'b000:  mem_sz = MEM_B;
            3'b001:  mem_sz = MEM_H;
            3'b010:  mem_sz = MEM_W;
            3'b100:  mem_sz = MEM_BU;
            3'b101:  mem_sz = MEM_HU;
            default: mem_sz = MEM_NONE;
          endcase
        end
        default: begin
          case (bus.funct3)
            3'b000:  begin alu_fn = ALU_XOR;  eqc = EQC_Z;  end
            3'b001:  begin alu_fn = ALU_XOR;  eqc = EQC_NZ; end
            3'b100:  begin alu_fn = ALU_SLT;  eqc = EQC_Z;  end
            3'b101:  begin alu_fn = ALU_SLT;  eqc = EQC_NZ; end
            3'b110:  begin alu_fn = ALU_SLTU; eqc = EQC_Z;  end
            3'b111:  begin alu_fn = ALU_SLTU; eqc = EQC_NZ; end
            default: begin alu_fn = ALU_ADD;  eqc = EQC_NONE; end
          endcase
        end
      endcase
    end
  end

  // Operand magnitudes and the cases that finish without iterating
  always_comb begin
    a_sgn    = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) && (bus.funct3 != F3_REMU);
    b_sgn    = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
               (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    a_neg    = a_sgn && bus.rs1_val[XLEN-1];
    b_neg    = b_sgn && bus.rs2_val[XLEN-1];
    a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
    b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
    div_zero = bus.funct3[2] && (bus.rs2_val == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.rs1_val == XMIN) && (bus.rs2_val == '1);
    if (div_zero) special_res = bus.funct3[1] ? bus.rs1_val : '1;
    else          special_res = bus.funct3[1] ? '0 : XMIN;
  end

  always_comb begin
    prod_s  = (a_neg_q ^ b_neg_q) ? -acc_nxt : acc_nxt;
    q_s     = (a_neg_q ^ b_neg_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    r_s     = a_neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (state_q == ST_DIV) fix_res = f3_q[1] ? r_s : q_s;
    else                   fix_res = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  muldiv_iter #(
    .XLEN      (XLEN),
    .MD_UNROLL (MD_UNROLL)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept),
    .step_i    (step),
    .is_div_i  (state_q == ST_DIV),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .acc_nxt_o (acc_nxt),
    .last_o    (iter_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      md_done_q   <= 1'b0;
      md_result_q <= '0;
      f3_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
    end else begin
      md_done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (m_op) begin
              f3_q    <= bus.funct3;
              a_neg_q <= a_neg;
              b_neg_q <= b_neg;
              if (div_zero || div_ovf) begin
                md_result_q <= special_res;
                md_done_q   <= 1'b1;
                state_q     <= ST_DONE;
              end else begin
                state_q <= bus.funct3[2] ? ST_DIV : ST_MUL;
              end
            end
          end
          ST_MUL, ST_DIV: begin
            if (iter_last) begin
              md_result_q <= fix_res;
              md_done_q   <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.out_to_alu = alu_fn;
  assign bus.equal_comp = eqc;
  assign bus.mem        = mem_sz;
  assign bus.md_busy    = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.md_done    = md_done_q;
  assign bus.md_result  = md_result_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode table, M-op results and latency, flush and reset.
module tb_alu_ctrl_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_en = 1'b0, op_valid = 1'b0, flush = 1'b0, sel4 = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0;
  logic [31:0] rs1 = '0, rs2 = '0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_muldiv_if #(.XLEN(32)) b1 ();
  alu_ctrl_muldiv_if #(.XLEN(32)) b4 ();

  assign b1.ALU_En = alu_en;  assign b4.ALU_En = alu_en;
  assign b1.op_valid = op_valid & ~sel4;
  assign b4.op_valid = op_valid & sel4;
  assign b1.alu_op = alu_op;  assign b4.alu_op = alu_op;
  assign b1.funct3 = funct3;  assign b4.funct3 = funct3;
  assign b1.funct7 = funct7;  assign b4.funct7 = funct7;
  assign b1.rs1_val = rs1;    assign b4.rs1_val = rs1;
  assign b1.rs2_val = rs2;    assign b4.rs2_val = rs2;
  assign b1.flush = flush;    assign b4.flush = flush;

  alu_ctrl_muldiv #(.XLEN(32), .MD_UNROLL(1), .EN_M(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_ctrl_muldiv #(.XLEN(32), .MD_UNROLL(4), .EN_M(1)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_o();
    return sel4 ? b4.md_busy : b1.md_busy;
  endfunction
  function automatic logic done_o();
    return sel4 ? b4.md_done : b1.md_done;
  endfunction
  function automatic logic [31:0] res_o();
    return sel4 ? b4.md_result : b1.md_result;
  endfunction
  function automatic logic [3:0] alu_o();
    return sel4 ? b4.out_to_alu : b1.out_to_alu;
  endfunction

  task automatic dec(input string tag, input logic en, input logic [1:0] aop, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [3:0] eo, input logic [1:0] ee, input logic [2:0] em);
    @(negedge clk);
    sel4 = 1'b0; alu_en = en; alu_op = aop; funct3 = f3; funct7 = f7; op_valid = 1'b1;
    #1;
    chk({tag, "/alu"}, b1.out_to_alu, eo);
    chk({tag, "/eq"}, b1.equal_comp, ee);
    chk({tag, "/mem"}, b1.mem, em);
    chk({tag, "/busy"}, b1.md_busy, 1'b0);
    op_valid = 1'b0; alu_en = 1'b0;
  endtask

  task automatic run_md(input string tag, input logic u4, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_busy);
    int cyc;
    cyc = 0;
    @(negedge clk);
    sel4 = u4; alu_en = 1'b0; alu_op = 2'b00; funct7 = 7'b0000001; funct3 = f3;
    rs1 = a; rs2 = b; op_valid = 1'b1;
    #1;
    chk({tag, "/alu"}, alu_o(), 4'b0010);
    while (busy_o() && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({tag, "/busy_cycles"}, cyc, exp_busy);
    chk({tag, "/done"}, done_o(), 1'b1);
    chk({tag, "/result"}, res_o(), exp);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk({tag, "/no_reaccept"}, {busy_o(), done_o()}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    #1;
    chk("rst/busy", b1.md_busy, 1'b0);
    chk("rst/done", b1.md_done, 1'b0);
    chk("rst/result", b1.md_result, 32'h0);
    chk("rst/result4", b4.md_result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    dec("r_add",  1'b0, 2'b00, 3'b000, 7'b0000000, 4'b0010, 2'b00, 3'b000);
    dec("r_sub",  1'b0, 2'b00, 3'b000, 7'b0100000, 4'b0110, 2'b00, 3'b000);
    dec("r_sra",  1'b0, 2'b00, 3'b101, 7'b0100000, 4'b1001, 2'b00, 3'b000);
    dec("r_sltu", 1'b0, 2'b00, 3'b011, 7'b0000000, 4'b0111, 2'b00, 3'b000);
    dec("i_addi", 1'b0, 2'b01, 3'b000, 7'b0100000, 4'b0010, 2'b00, 3'b000);
    dec("i_srai", 1'b0, 2'b01, 3'b101, 7'b0100000, 4'b1001, 2'b00, 3'b000);
    dec("i_ori",  1'b0, 2'b01, 3'b110, 7'b0100000, 4'b0001, 2'b00, 3'b000);
    dec("ld_hu",  1'b0, 2'b10, 3'b101, 7'b0000000, 4'b0010, 2'b00, 3'b100);
    dec("ld_b",   1'b0, 2'b10, 3'b000, 7'b0000000, 4'b0010, 2'b00, 3'b001);
    dec("br_ltu", 1'b0, 2'b11, 3'b110, 7'b0000000, 4'b0111, 2'b11, 3'b000);
    dec("br_ne",  1'b0, 2'b11, 3'b001, 7'b0000000, 4'b0011, 2'b10, 3'b000);
    dec("br_ge",  1'b0, 2'b11, 3'b101, 7'b0000000, 4'b0101, 2'b10, 3'b000);
    dec("en_br",  1'b1, 2'b11, 3'b110, 7'b0000000, 4'b0010, 2'b00, 3'b000);
    dec("en_mop", 1'b1, 2'b00, 3'b100, 7'b0000001, 4'b0010, 2'b00, 3'b000);

    run_md("mul",      1'b0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_md("mulhu",    1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("mulh",     1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_md("mulhsu",   1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_md("div",      1'b0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_md("rem",      1'b0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_md("divu_z",   1'b0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_md("remu_z",   1'b0, 3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_md("div_ovf",  1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("rem_ovf",  1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
    run_md("divu",     1'b0, 3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_md("remu",     1'b0, 3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_md("rem_negb", 1'b0, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);

    // flush on busy cycle 10 of a DIVU; result must keep the previous value (1)
    @(negedge clk);
    sel4 = 1'b0; alu_op = 2'b00; funct7 = 7'b0000001; funct3 = 3'b101;
    rs1 = 32'd100; rs2 = 32'd7; op_valid = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    chk("flush/busy_c10", b1.md_busy, 1'b1);
    flush = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush/busy", b1.md_busy, 1'b0);
    chk("flush/result", b1.md_result, 32'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      seen_done = seen_done | b1.md_done;
    end
    chk("flush/no_done", seen_done, 1'b0);

    // flush and accept in the same cycle: flush wins
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; op_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_acc/busy", b1.md_busy, 1'b0);
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_acc/idle", {b1.md_busy, b1.md_done}, 2'b00);

    run_md("mul_u4", 1'b1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 9);
    run_md("div_u4", 1'b1, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 9);

    // async reset mid-DIV
    @(negedge clk);
    sel4 = 1'b1; funct7 = 7'b0000001; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; op_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid/busy_before", b4.md_busy, 1'b1);
    rst_n = 1'b0; op_valid = 1'b0;
    #1;
    chk("rst_mid/busy", b4.md_busy, 1'b0);
    chk("rst_mid/done", b4.md_done, 1'b0);
    chk("rst_mid/result", b4.md_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
